// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
//   Shared definitions for the pipelined LEGv8 immediate generator:
//     - fmt_t         : format code reported alongside every immediate
//     - OPC_*         : opcode match values for every recognised instruction
//     - *_OP_LO       : low bit of each opcode field (opcode always ends at 31)
//     - *_IMM_HI/LO/W : position and width of each immediate field
// -----------------------------------------------------------------------------
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_t;

    // Opcode field low bits; every opcode field runs from bit 31 down to these.
    localparam int B_OP_LO  = 26;
    localparam int CB_OP_LO = 24;
    localparam int D_OP_LO  = 21;
    localparam int I_OP_LO  = 22;
    localparam int IW_OP_LO = 23;

    // Opcode match values
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [5:0]  OPC_BL    = 6'b100101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [7:0]  OPC_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI  = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;

    // Immediate field positions
    localparam int B_IMM_HI  = 25;
    localparam int B_IMM_LO  = 0;
    localparam int CB_IMM_HI = 23;
    localparam int CB_IMM_LO = 5;
    localparam int D_IMM_HI  = 20;
    localparam int D_IMM_LO  = 12;
    localparam int I_IMM_HI  = 21;
    localparam int I_IMM_LO  = 10;
    localparam int IW_IMM_HI = 20;
    localparam int IW_IMM_LO = 5;
    localparam int IW_HW_HI  = 22;
    localparam int IW_HW_LO  = 21;

    localparam int B_IMM_W  = B_IMM_HI  - B_IMM_LO  + 1;
    localparam int CB_IMM_W = CB_IMM_HI - CB_IMM_LO + 1;
    localparam int D_IMM_W  = D_IMM_HI  - D_IMM_LO  + 1;
    localparam int I_IMM_W  = I_IMM_HI  - I_IMM_LO  + 1;
    localparam int IW_IMM_W = IW_IMM_HI - IW_IMM_LO + 1;

    // All extension is done at this width, then truncated to DATA_W.
    localparam int WIDE_W = 64;

endpackage

// File: rtl/imm_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
//   Combinational format decode and immediate extension.
//   Parameters:
//     DATA_W   : result width, 32 or 64
//     BR_SHIFT : nonzero -> B/CB immediates shifted left by 2 after extension
//   Ports:
//     instr : 32-bit instruction word
//     imm   : extended immediate (DATA_W)
//     fmt   : format code (fmt_t encoding)
//     err   : immediate not representable in DATA_W (MOVZ hw>=2 at 32 bits)
// -----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] imm,
    output logic [2:0]        fmt,
    output logic              err
);

    logic [B_IMM_W-1:0]  b_field;
    logic [CB_IMM_W-1:0] cb_field;
    logic [D_IMM_W-1:0]  d_field;
    logic [I_IMM_W-1:0]  i_field;
    logic [IW_IMM_W-1:0] iw_field;
    logic [1:0]          iw_hw;

    assign b_field  = instr[B_IMM_HI:B_IMM_LO];
    assign cb_field = instr[CB_IMM_HI:CB_IMM_LO];
    assign d_field  = instr[D_IMM_HI:D_IMM_LO];
    assign i_field  = instr[I_IMM_HI:I_IMM_LO];
    assign iw_field = instr[IW_IMM_HI:IW_IMM_LO];
    assign iw_hw    = instr[IW_HW_HI:IW_HW_LO];

    fmt_t              fmt_c;
    logic [WIDE_W-1:0] wide;
    logic              err_c;

    always_comb begin
        fmt_c = FMT_NONE;
        wide  = '0;
        err_c = 1'b0;

        // Priority order matters: the first matching format wins.
        if (instr[31:B_OP_LO] == OPC_B || instr[31:B_OP_LO] == OPC_BL) begin
            fmt_c = FMT_B;
            wide  = {{(WIDE_W-B_IMM_W){b_field[B_IMM_W-1]}}, b_field};
        end else if (instr[31:CB_OP_LO] == OPC_CBZ  ||
                     instr[31:CB_OP_LO] == OPC_CBNZ ||
                     instr[31:CB_OP_LO] == OPC_BCOND) begin
            fmt_c = FMT_CB;
            wide  = {{(WIDE_W-CB_IMM_W){cb_field[CB_IMM_W-1]}}, cb_field};
        end else if (instr[31:D_OP_LO] == OPC_LDUR || instr[31:D_OP_LO] == OPC_STUR) begin
            fmt_c = FMT_D;
            wide  = {{(WIDE_W-D_IMM_W){d_field[D_IMM_W-1]}}, d_field};
        end else if (instr[31:I_OP_LO] == OPC_ADDI || instr[31:I_OP_LO] == OPC_SUBI) begin
            fmt_c = FMT_I;
            wide  = {{(WIDE_W-I_IMM_W){1'b0}}, i_field};
        end else if (instr[31:IW_OP_LO] == OPC_MOVZ) begin
            fmt_c = FMT_IW;
            // Shift amount is 16*hw, i.e. hw concatenated with four zero bits.
            wide  = {{(WIDE_W-IW_IMM_W){1'b0}}, iw_field} << {iw_hw, 4'b0000};
            // hw of 2 or 3 places the halfword entirely above a 32-bit result.
            if (DATA_W == 32 && iw_hw[1]) begin
                wide  = '0;
                err_c = 1'b1;
            end
        end

        // Word-to-byte offset conversion; bits pushed past DATA_W are simply lost.
        if (BR_SHIFT != 0 && (fmt_c == FMT_B || fmt_c == FMT_CB)) begin
            wide = wide << 2;
        end
    end

    assign imm = wide[DATA_W-1:0];
    assign fmt = fmt_c;
    assign err = err_c;

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//   One-deep pipelined immediate generator between decode and register read.
//   Parameters:
//     DATA_W   : immediate width, 32 or 64
//     TAG_W    : sideband tag (PC) width
//     BR_SHIFT : nonzero -> B/CB immediates are byte offsets (<<2)
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     in_valid/in_ready   : input handshake
//     in_instr, in_tag    : instruction word and its tag
//     flush               : drop the held entry, block acceptance this cycle
//     out_valid/out_ready : output handshake
//     out_imm/out_fmt/out_err/out_tag : held result
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and data until that edge. in_ready depends on
// out_ready combinationally, so a full stage can drain and refill in the same
// cycle; while out_valid && !out_ready the held result stays stable.
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 64,
    parameter int BR_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_fmt,
    output logic              out_err,
    output logic [TAG_W-1:0]  out_tag
);

    logic [DATA_W-1:0] dec_imm;
    logic [2:0]        dec_fmt;
    logic              dec_err;
    logic              accept;

    imm_decode #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt),
        .err   (dec_err)
    );

    // Reset and flush both close the input so nothing slips in alongside them.
    assign in_ready = !reset && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_fmt   <= '0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_imm   <= dec_imm;
            out_fmt   <= dec_fmt;
            out_err   <= dec_err;
            out_tag   <= in_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_tag;
  logic        flush;
  logic        out_ready;

  // default instance: DATA_W=64, BR_SHIFT=0
  logic        a_in_ready, a_out_valid, a_out_err;
  logic [63:0] a_out_imm, a_out_tag;
  logic [2:0]  a_out_fmt;
  // BR_SHIFT=1 instance
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [63:0] s_out_imm, s_out_tag;
  logic [2:0]  s_out_fmt;
  // DATA_W=32 instance
  logic        n_in_ready, n_out_valid, n_out_err;
  logic [31:0] n_out_imm;
  logic [63:0] n_out_tag;
  logic [2:0]  n_out_fmt;

  int checks = 0;
  int errors = 0;

  imm_gen_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
    .out_err(a_out_err), .out_tag(a_out_tag)
  );

  imm_gen_pipe #(.BR_SHIFT(1)) u_dut_shift (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_imm(s_out_imm), .out_fmt(s_out_fmt),
    .out_err(s_out_err), .out_tag(s_out_tag)
  );

  imm_gen_pipe #(.DATA_W(32)) u_dut_32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_imm(n_out_imm), .out_fmt(n_out_fmt),
    .out_err(n_out_err), .out_tag(n_out_tag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // all driving and sampling happens on the falling edge
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_tag = 64'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if ({a_out_imm, a_out_fmt, a_out_err, a_out_tag} !== '0) begin errors++;
      $display("FAIL reset_outputs: imm %h fmt %0d err %b tag %h expected all 0", a_out_imm, a_out_fmt, a_out_err, a_out_tag); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; in_instr = 32'h17FF_FFFF; in_tag = 64'h1000;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || a_out_fmt !== 3'd1) begin errors++;
      $display("FAIL b_imm64: valid %b imm %h fmt %0d expected 1 ffffffffffffffff 1", a_out_valid, a_out_imm, a_out_fmt); end
    checks++; if (a_out_tag !== 64'h1000 || a_out_err !== 1'b0) begin errors++;
      $display("FAIL b_tag_err: tag %h err %b expected 1000 0", a_out_tag, a_out_err); end
    checks++; if (s_out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || s_out_fmt !== 3'd1) begin errors++;
      $display("FAIL b_shift: imm %h fmt %0d expected fffffffffffffffc 1", s_out_imm, s_out_fmt); end
    checks++; if (n_out_imm !== 32'hFFFF_FFFF || n_out_err !== 1'b0) begin errors++;
      $display("FAIL b_imm32: imm %h err %b expected ffffffff 0", n_out_imm, n_out_err); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b_drain: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'hB480_0000; in_tag = 64'h2000;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'hFFFF_FFFF_FFFC_0000 || a_out_fmt !== 3'd2) begin errors++;
      $display("FAIL cbz: valid %b imm %h fmt %0d expected 1 fffffffffffc0000 2", a_out_valid, a_out_imm, a_out_fmt); end
    checks++; if (s_out_imm !== 64'hFFFF_FFFF_FFF0_0000) begin errors++;
      $display("FAIL cbz_shift: imm %h expected fffffffffff00000", s_out_imm); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", a_in_ready); end
    in_instr = 32'hF850_0000; in_tag = 64'h2004;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'hFFFF_FFFF_FFFF_FF00 || a_out_fmt !== 3'd3 || a_out_tag !== 64'h2004) begin errors++;
      $display("FAIL ldur: valid %b imm %h fmt %0d tag %h expected 1 ffffffffffffff00 3 2004", a_out_valid, a_out_imm, a_out_fmt, a_out_tag); end
    checks++; if (s_out_imm !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++;
      $display("FAIL ldur_noshift: imm %h expected ffffffffffffff00", s_out_imm); end
    @(negedge clk);
  endtask

  task automatic test_addi_none();
    in_valid = 1'b1; in_instr = 32'h913F_FC00; in_tag = 64'h3000;
    @(negedge clk);
    checks++; if (a_out_imm !== 64'h0000_0000_0000_0FFF || a_out_fmt !== 3'd4 || n_out_imm !== 32'h0000_0FFF) begin errors++;
      $display("FAIL addi: imm %h fmt %0d imm32 %h expected fff 4 fff", a_out_imm, a_out_fmt, n_out_imm); end
    in_instr = 32'h0000_0000; in_tag = 64'h3004;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'h0 || a_out_fmt !== 3'd0 || a_out_err !== 1'b0) begin errors++;
      $display("FAIL none: valid %b imm %h fmt %0d err %b expected 1 0 0 0", a_out_valid, a_out_imm, a_out_fmt, a_out_err); end
    @(negedge clk);
  endtask

  task automatic test_movz();
    in_valid = 1'b1; in_instr = 32'hD2F5_79A0; in_tag = 64'h4000;
    @(negedge clk);
    checks++; if (a_out_imm !== 64'hABCD_0000_0000_0000 || a_out_fmt !== 3'd5 || a_out_err !== 1'b0) begin errors++;
      $display("FAIL movz64: imm %h fmt %0d err %b expected abcd000000000000 5 0", a_out_imm, a_out_fmt, a_out_err); end
    checks++; if (n_out_imm !== 32'h0 || n_out_fmt !== 3'd5 || n_out_err !== 1'b1) begin errors++;
      $display("FAIL movz32_hw3: imm %h fmt %0d err %b expected 0 5 1", n_out_imm, n_out_fmt, n_out_err); end
    // hw=1 still fits in 32 bits
    in_instr = 32'hD2B5_79A0; in_tag = 64'h4004;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (n_out_imm !== 32'hABCD_0000 || n_out_err !== 1'b0) begin errors++;
      $display("FAIL movz32_hw1: imm %h err %b expected abcd0000 0", n_out_imm, n_out_err); end
    checks++; if (a_out_imm !== 64'h0000_0000_ABCD_0000) begin errors++;
      $display("FAIL movz64_hw1: imm %h expected 00000000abcd0000", a_out_imm); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h913F_FC00; in_tag = 64'h5000;
    @(negedge clk);
    // a second instruction waits at the input during the stall
    in_instr = 32'h17FF_FFFF; in_tag = 64'h5004;
    for (int i = 0; i < 3; i++) begin
      checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'hFFF || a_out_fmt !== 3'd4 || a_out_tag !== 64'h5000) begin errors++;
        $display("FAIL stall_hold_%0d: valid %b imm %h fmt %0d tag %h expected 1 fff 4 5000", i, a_out_valid, a_out_imm, a_out_fmt, a_out_tag); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready_%0d: got %b expected 0", i, a_in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", a_in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || a_out_tag !== 64'h5004) begin errors++;
      $display("FAIL release_next: valid %b imm %h tag %h expected 1 ffffffffffffffff 5004", a_out_valid, a_out_imm, a_out_tag); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL release_no_dup: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h913F_FC00; in_tag = 64'h6000;
    @(negedge clk);
    in_instr = 32'hB480_0000; in_tag = 64'h6004;
    flush = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", a_in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b expected 0", a_out_valid); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_not_accepted: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hD2F5_79A0; in_tag = 64'h7000;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", a_out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({a_out_valid, a_out_imm, a_out_fmt, a_out_err, a_out_tag} !== '0) begin errors++;
      $display("FAIL reset_mid: valid %b imm %h fmt %0d err %b tag %h expected all 0", a_out_valid, a_out_imm, a_out_fmt, a_out_err, a_out_tag); end
    checks++; if ({n_out_valid, n_out_imm, n_out_err} !== '0 || a_in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_mid_32: valid %b imm %h err %b in_ready %b expected 0 0 0 0", n_out_valid, n_out_imm, n_out_err, a_in_ready); end
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_branch();
    test_back_to_back();
    test_addi_none();
    test_movz();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
